// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
// Byte FIFO that feeds a serial transmitter over a start/busy handshake.
//
// Handshake: a byte is offered by holding tx_start=1 with tx_data stable.
//   The transmitter acknowledges by raising tx_busy, which is seen here only
//   through a two-flop synchroniser (busy_s). tx_start drops once busy_s=1 and
//   the next byte is not offered until busy_s has fallen again. If busy_s
//   never rises within ACK_TIMEOUT cycles, the byte is discarded and the
//   sticky tx_timeout flag is raised.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   ACK_TIMEOUT  cycles to wait in REQ for busy_s before giving up
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   wr_en, wr_data    byte write strobe and data (dropped when full)
//   full, empty       registered FIFO status
//   level             registered FIFO occupancy
//   tx_data, tx_start byte and request level to the transmitter
//   tx_busy           transmitter status (may be asynchronous to clk)
//   tx_timeout        sticky acknowledge-timeout flag (cleared by reset only)
//   ovf, ovf_cnt      only with UART_TX_FEEDER_OVF_EN: sticky drop flag and
//                     saturating count of dropped writes
//   o_dbg_state       FSM state: 0 IDLE, 1 REQ, 2 SEND
//
// Optional feature macro: UART_TX_FEEDER_OVF_EN
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 400000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     tx_timeout,
`ifdef UART_TX_FEEDER_OVF_EN
  output logic                     ovf,
  output logic [7:0]               ovf_cnt,
`endif
  output logic [1:0]               o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_full;
  logic          r_empty;
  logic          r_busy_meta;
  logic          r_busy_s;
  logic [1:0]    r_state;
  logic [CW-1:0] r_wait;
  logic [7:0]    r_tx_data;
  logic          r_tx_start;
  logic          r_tx_timeout;

  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level_nxt;

  // A write is judged against the registered full flag, so a pop in the same
  // cycle does not make room for it.
  assign w_push = wr_en & ~r_full;
  assign w_pop  = (r_state == IDLE) & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  // Storage needs no reset; only pointers and status are reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  // Two-flop synchroniser for the transmitter's busy status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_meta <= 1'b0;
      r_busy_s    <= 1'b0;
    end else begin
      r_busy_meta <= tx_busy;
      r_busy_s    <= r_busy_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wait       <= '0;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_wait     <= '0;
            r_state    <= REQ;
          end
        end
        REQ: begin
          // Acknowledge wins over a timeout expiring in the same cycle.
          if (r_busy_s) begin
            r_tx_start <= 1'b0;
            r_state    <= SEND;
          end else if (r_wait == CW'(ACK_TIMEOUT - 1)) begin
            r_tx_timeout <= 1'b1;
            r_tx_start   <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        SEND: begin
          // Leaving only on busy_s low keeps consecutive bytes apart.
          if (!r_busy_s) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic       r_ovf;
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= 8'h00;
    end else if (wr_en && r_full) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign ovf     = r_ovf;
  assign ovf_cnt = r_ovf_cnt;
`endif

  assign full        = r_full;
  assign empty       = r_empty;
  assign level       = r_level;
  assign tx_data     = r_tx_data;
  assign tx_start    = r_tx_start;
  assign tx_timeout  = r_tx_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder
// Directed + randomized bench for uart_tx_feeder (DEPTH=8, ACK_TIMEOUT=16).
// A reference queue holds accepted bytes; a pop is recognised from the
// outside as a rising edge of tx_start, at which the offered byte must equal
// the queue head. Occupancy/full/empty are checked against the queue size
// every cycle. A transmitter process drives tx_busy in one of three modes.
// -----------------------------------------------------------------------------
module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int ACK_T = 16;
  localparam int X_NORMAL = 0;
  localparam int X_STUCK  = 1;
  localparam int X_MUTE   = 2;

  // clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [3:0] level;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_timeout;
  logic [1:0] o_dbg_state;
`ifdef UART_TX_FEEDER_OVF_EN
  logic       ovf;
  logic [7:0] ovf_cnt;
`endif

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_timeout (tx_timeout),
`ifdef UART_TX_FEEDER_OVF_EN
    .ovf        (ovf),
    .ovf_cnt    (ovf_cnt),
`endif
    .o_dbg_state(o_dbg_state)
  );

  // scoreboard state
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         drop_cnt = 0;
  int         n_pops   = 0;
  int         overlap  = 0;
  logic       prev_start = 1'b0;
  logic [7:0] last_byte  = 8'h00;

  // transmitter model controls
  int xmode     = X_NORMAL;
  int busy_len  = 4;
  bit rand_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance, then update the reference model and check outputs.
  task automatic step();
    logic       w;
    logic [7:0] d;
    w = wr_en;
    d = wr_data;
    @(posedge clk); #1;
    if (w) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else drop_cnt++;
    end
    if (tx_start && !prev_start) begin
      n_pops++;
      chk("pop_avail", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        last_byte = exp_q.pop_front();
      end
    end
    prev_start = tx_start;
    chk("tx_data", tx_data, last_byte);
    chk("level", level, exp_q.size());
    chk("full", full, 32'(exp_q.size() == DEPTH));
    chk("empty", empty, 32'(exp_q.size() == 0));
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf", ovf, 32'(drop_cnt > 0));
    chk("ovf_cnt", ovf_cnt, (drop_cnt > 255) ? 255 : drop_cnt);
`endif
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  // Run until the model queue is empty and the FSM is back in IDLE.
  task automatic drain(input string tag, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      step();
      if (exp_q.size() == 0 && o_dbg_state == 2'd0 && !tx_start) done = 1'b1;
    end
    chk(tag, done, 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    prev_start = 1'b0;
    last_byte  = 8'h00;
    drop_cnt   = 0;
  endtask

  // transmitter model
  initial begin : xmit
    int  busy_cnt;
    bit  seen;
    bit  new_req;
    tx_busy  = 1'b0;
    busy_cnt = 0;
    seen     = 1'b0;
    forever begin
      @(posedge clk); #1;
      new_req = tx_start && !seen;
      seen    = tx_start;
      case (xmode)
        X_NORMAL: begin
          if (new_req && tx_busy) overlap++;
          if (new_req) busy_cnt = rand_busy ? int'($urandom_range(1, 12)) : busy_len;
          if (busy_cnt > 0) begin
            tx_busy = 1'b1;
            busy_cnt--;
          end else begin
            tx_busy = 1'b0;
          end
        end
        X_STUCK: tx_busy = 1'b1;
        default: tx_busy = 1'b0;
      endcase
    end
  end

  initial begin : main
    int   cnt;
    bit   found;
    logic [7:0] seq [4];

    // reset
    rst_n   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_timeout", tx_timeout, 0);
    chk("rst_state", o_dbg_state, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_state", o_dbg_state, 0);

    // single byte, latency
    busy_len = 4;
    write_byte(8'h85);
    chk("lat_empty_n1", empty, 0);
    chk("lat_start_n1", tx_start, 0);
    step();
    chk("lat_start_n2", tx_start, 1);
    chk("lat_data_n2", tx_data, 8'h85);
    cnt = 1;
    for (int i = 0; i < 40 && tx_start; i++) begin
      step();
      if (tx_start) cnt++;
    end
    chk("ack_before_timeout", 32'(cnt < ACK_T), 1);
    chk("no_timeout", tx_timeout, 0);
    drain("single_idle", 60);
    chk("single_state_idle", o_dbg_state, 0);

    // ordering with 10-cycle busy
    busy_len = 10;
    seq[0] = 8'h12; seq[1] = 8'h34; seq[2] = 8'h56; seq[3] = 8'h11;
    n_pops = 0;
    for (int i = 0; i < 4; i++) write_byte(seq[i]);
    drain("order_drain", 200);
    chk("order_pops", n_pops, 4);
    chk("order_last", tx_data, 8'h11);

    // randomized traffic
    rand_busy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    drain("rand_drain", 400);
    rand_busy = 1'b0;

    // full / overflow with transmitter stalled
    xmode = X_STUCK;
    write_byte(8'($urandom));
    repeat (6) step();
    chk("stall_state_send", o_dbg_state, 2);
    drop_cnt = 0;
    for (int i = 0; i < 9; i++) write_byte(8'($urandom));
    step();
    chk("ovf_full", full, 1);
    chk("ovf_level", level, 8);
    chk("ovf_drops", drop_cnt, 1);
    xmode    = X_NORMAL;
    busy_len = 3;
    drain("ovf_drain", 300);

    // simultaneous write and pop at level 4
    xmode = X_STUCK;
    write_byte(8'($urandom));
    repeat (5) step();
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    chk("sim_level_pre", level, 4);
    xmode    = X_NORMAL;
    busy_len = 2;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (o_dbg_state == 2'd0 && !empty) found = 1'b1;
    end
    chk("sim_reach_pop", found, 1);
    write_byte(8'($urandom));
    chk("sim_level_post", level, 4);
    drain("sim_drain", 300);

    // acknowledge timeout
    xmode = X_MUTE;
    write_byte(8'hA5);
    write_byte(8'h5A);
    found = tx_start;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = tx_start;
    end
    chk("to_req_seen", found, 1);
    chk("to_req_data", tx_data, 8'hA5);
    cnt = 1;
    for (int i = 0; i < 40 && tx_start; i++) begin
      step();
      if (tx_start) cnt++;
    end
    chk("to_req_cycles", cnt, ACK_T);
    chk("to_flag", tx_timeout, 1);
    chk("to_start_low", tx_start, 0);
    xmode = X_NORMAL;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = tx_start;
    end
    chk("to_next_req", found, 1);
    chk("to_next_data", tx_data, 8'h5A);
    drain("to_drain", 100);
    chk("to_sticky", tx_timeout, 1);

    // reset while in SEND with level 3
    xmode = X_STUCK;
    write_byte(8'($urandom));
    repeat (5) step();
    for (int i = 0; i < 3; i++) write_byte(8'($urandom));
    chk("mid_level", level, 3);
    chk("mid_state_send", o_dbg_state, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_data", tx_data, 8'h00);
    chk("mid_rst_timeout", tx_timeout, 0);
    chk("mid_rst_state", o_dbg_state, 0);
    model_reset();
    xmode = X_NORMAL;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    write_byte(8'h3C);
    chk("resume_empty", empty, 0);
    drain("resume_drain", 100);
    chk("resume_data", tx_data, 8'h3C);

    chk("no_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
